// File: rtl/clk_step_ctrl_if.sv
// clk_step_ctrl_if
//   Bundles the control and status signals of the CPU clocking controller.
//   master : the side that drives mode/button/burst_len/halt_req (board, bench)
//   slave  : the controller itself, which drives cpu_en/busy/step_cnt
// Signals
//   mode      2        00=RUN, 01=STEP, 10=BURST, 11=HALT
//   button    1        raw asynchronous push-button
//   burst_len BURST_W  steps per burst, sampled when a burst starts
//   halt_req  1        synchronous stop request from the CPU
//   cpu_en    1        one-sysclk-wide clock-enable pulse
//   busy      1        high while running or bursting
//   step_cnt  16       number of cpu_en pulses issued (wraps)
interface clk_step_ctrl_if #(
  parameter int BURST_W = 8
);
  logic [1:0]         mode;
  logic               button;
  logic [BURST_W-1:0] burst_len;
  logic               halt_req;
  logic               cpu_en;
  logic               busy;
  logic [15:0]        step_cnt;

  modport master (
    output mode, button, burst_len, halt_req,
    input  cpu_en, busy, step_cnt
  );

  modport slave (
    input  mode, button, burst_len, halt_req,
    output cpu_en, busy, step_cnt
  );
endinterface

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl
//   CPU clocking controller. Produces a one-sysclk-wide clock-enable (cpu_en)
//   in one of four modes: free-run at a divided rate, single step per
//   debounced button press, N-step burst, or halt. The CPU runs on sysclk
//   and only advances when cpu_en is high. Issued steps are counted.
// Ports
//   sysclk  system clock, all logic on the rising edge
//   rst     asynchronous active-high reset
//   bus     clk_step_ctrl_if.slave (mode, button, burst_len, halt_req in;
//           cpu_en, busy, step_cnt out)
// Parameters
//   DIV        tick period in sysclk cycles for RUN and BURST (>=2)
//   DB_CYCLES  cycles the synchronised button must differ before accepted (>=1)
//   BURST_W    width of burst_len and the remaining-steps counter
module clk_step_ctrl #(
  parameter int DIV       = 50_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int BURST_W   = 8
) (
  input logic          sysclk,
  input logic          rst,
  clk_step_ctrl_if.slave bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DB_W  = $clog2(DB_CYCLES + 1);

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_HALT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BURST,
    HALTED
  } state_t;

  state_t             state;
  logic               sync1;
  logic               btn_s;
  logic               db_level;
  logic               db_level_d;
  logic [DB_W-1:0]    db_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         mode_q;
  logic [BURST_W-1:0] remaining;
  logic               cpu_en_q;
  logic               busy_q;
  logic [15:0]        step_q;

  logic press;
  logic tick;
  logic mode_change;
  logic burst_start;

  assign press       = db_level & ~db_level_d;
  assign tick        = (div_cnt == DIV_W'(DIV - 1));
  assign mode_change = (bus.mode != mode_q);
  assign burst_start = (state == IDLE) && !bus.halt_req && (bus.mode == MODE_BURST) &&
                       press && (bus.burst_len != '0);

  assign bus.cpu_en   = cpu_en_q;
  assign bus.busy     = busy_q;
  assign bus.step_cnt = step_q;

  // Two-flop synchroniser followed by a stability counter. The level only
  // flips after the synchronised button has disagreed with it for DB_CYCLES
  // consecutive cycles; any agreement restarts the count.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      btn_s      <= 1'b0;
      db_level   <= 1'b0;
      db_level_d <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync1      <= bus.button;
      btn_s      <= sync1;
      db_level_d <= db_level;
      if (btn_s != db_level) begin
        if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
          db_level <= btn_s;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Tick divider. Restarting it on a mode change or burst start makes the
  // first pulse land a full period later, which keeps cpu_en from ever
  // firing on two consecutive cycles.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      mode_q  <= MODE_RUN;
    end else begin
      mode_q <= bus.mode;
      if (mode_change || burst_start || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Main controller. halt_req overrides everything so that cpu_en is
  // guaranteed low the cycle after it is raised; step_q advances on the
  // same edge that raises cpu_en so both become visible together.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpu_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      step_q    <= '0;
      remaining <= '0;
    end else begin
      cpu_en_q <= 1'b0;
      if (bus.halt_req) begin
        state     <= HALTED;
        busy_q    <= 1'b0;
        remaining <= '0;
      end else begin
        case (state)
          IDLE: begin
            case (bus.mode)
              MODE_RUN: begin
                state  <= RUN;
                busy_q <= 1'b1;
              end
              MODE_STEP: begin
                if (press) begin
                  cpu_en_q <= 1'b1;
                  step_q   <= step_q + 16'd1;
                end
              end
              MODE_BURST: begin
                if (burst_start) begin
                  state     <= BURST;
                  busy_q    <= 1'b1;
                  remaining <= bus.burst_len;
                end
              end
              MODE_HALT: begin
                state <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end
          RUN: begin
            if (bus.mode != MODE_RUN) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else if (tick) begin
              cpu_en_q <= 1'b1;
              step_q   <= step_q + 16'd1;
            end
          end
          BURST: begin
            if (bus.mode != MODE_BURST) begin
              state     <= IDLE;
              busy_q    <= 1'b0;
              remaining <= '0;
            end else if (tick) begin
              cpu_en_q  <= 1'b1;
              step_q    <= step_q + 16'd1;
              remaining <= remaining - BURST_W'(1);
              if (remaining == BURST_W'(1)) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end
          end
          HALTED: begin
            if (press) begin
              state <= IDLE;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
